// File: rtl/sync_lock_ctrl.sv
// Line-lock controller: qualifies detected hsync edges against the nominal line
// period and drives a flywheel-regenerated hsync, gated vsync and line numbering.
module sync_lock_ctrl #(
   parameter int unsigned LINE_TIME  = 1536,
   parameter int unsigned HSYNC_TIME = 113,
   parameter int unsigned TOL        = 24,
   parameter int unsigned LOCK_LINES = 8,
   parameter int unsigned MISS_MAX   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       locked,
   output logic [9:0] line_count,
   output logic [9:0] field_lines,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2,
      ST_COAST  = 2'd3
   } state_t;

   localparam int unsigned FW_W = $clog2(LINE_TIME);
   localparam int unsigned GC_W = $clog2(LOCK_LINES + 1);
   localparam int unsigned MC_W = $clog2(MISS_MAX + 1);

   localparam logic [FW_W-1:0] FW_LAST = FW_W'(LINE_TIME - 1);
   localparam logic [FW_W-1:0] WIN_LO  = FW_W'(LINE_TIME - TOL);
   localparam logic [FW_W-1:0] WIN_HI  = FW_W'(TOL);
   localparam logic [FW_W-1:0] HIT_CLR = FW_W'(TOL + 1);
   localparam logic [FW_W-1:0] HS_END  = FW_W'(HSYNC_TIME);
   localparam logic [15:0]     PC_MIN  = 16'(LINE_TIME - TOL);
   localparam logic [15:0]     PC_MAX  = 16'(LINE_TIME + TOL);
   localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_LINES - 1);
   localparam logic [MC_W-1:0] MC_LAST = MC_W'(MISS_MAX - 1);

   state_t          state_q, state_d;
   logic            hsync_in_z, vsync_in_z;
   logic [15:0]     pc;
   logic [FW_W-1:0] fw, fw_d;
   logic [GC_W-1:0] good_cnt, good_cnt_d;
   logic [MC_W-1:0] miss_cnt, miss_cnt_d;
   logic            hit, hit_d;
   logic [9:0]      line_d, field_d;
   logic            fall_h, fall_v;
   logic            valid_period, in_window, is_lock;
   logic            rephase, line_inc;

   assign fall_h       = hsync_in_z & ~hsync_in;
   assign fall_v       = vsync_in_z & ~vsync_in;
   assign valid_period = (pc >= PC_MIN) && (pc <= PC_MAX);
   assign in_window    = (fw >= WIN_LO) || (fw <= WIN_HI);
   assign is_lock      = (state_q == ST_LOCKED) || (state_q == ST_COAST);
   assign state        = state_q;

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt;
      miss_cnt_d = miss_cnt;
      rephase    = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (fall_h && valid_period) begin
               state_d    = ST_VERIFY;
               good_cnt_d = GC_W'(1);
               rephase    = 1'b1;
            end
         end
         ST_VERIFY: begin
            if (fall_h) begin
               if (valid_period) begin
                  rephase    = 1'b1;
                  good_cnt_d = good_cnt + 1'b1;
                  if (good_cnt == GC_LAST) begin
                     state_d    = ST_LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  state_d    = ST_SEARCH;
                  good_cnt_d = '0;
               end
            end
         end
         ST_LOCKED, ST_COAST: begin
            if (fall_h && in_window) begin
               rephase    = 1'b1;
               state_d    = ST_LOCKED;
               miss_cnt_d = '0;
            end else if ((fw == WIN_HI) && !hit) begin
               if (state_q == ST_LOCKED) begin
                  state_d    = ST_COAST;
                  miss_cnt_d = MC_W'(1);
               end else begin
                  miss_cnt_d = miss_cnt + 1'b1;
                  if (miss_cnt == MC_LAST) begin
                     state_d    = ST_SEARCH;
                     good_cnt_d = '0;
                  end
               end
            end
         end
      endcase

      hit_d = hit;
      if (rephase)
         hit_d = 1'b1;
      else if (fw == HIT_CLR)
         hit_d = 1'b0;

      fw_d = '0;
      if (!rephase && (fw != FW_LAST))
         fw_d = fw + 1'b1;

      // An early rephase stands in for the wrap it pre-empts; a late one follows
      // a wrap already counted, so each line advances the count exactly once.
      line_inc = rephase ? (fw >= WIN_LO) : (fw == FW_LAST);

      line_d  = line_count;
      field_d = field_lines;
      if (fall_v && is_lock) begin
         field_d = line_count;
         line_d  = '0;
      end else if (line_inc && (line_count != '1)) begin
         line_d = line_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         hsync_in_z  <= 1'b1;
         vsync_in_z  <= 1'b1;
         pc          <= '0;
         fw          <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         hit         <= 1'b0;
         line_count  <= '0;
         field_lines <= '0;
         hsync_out   <= 1'b1;
         vsync_out   <= 1'b1;
         locked      <= 1'b0;
      end else begin
         if (ce) begin
            hsync_in_z  <= hsync_in;
            vsync_in_z  <= vsync_in;
            if (fall_h)
               pc <= '0;
            else if (pc != '1)
               pc <= pc + 16'd1;
            state_q     <= state_d;
            fw          <= fw_d;
            good_cnt    <= good_cnt_d;
            miss_cnt    <= miss_cnt_d;
            hit         <= hit_d;
            line_count  <= line_d;
            field_lines <= field_d;
         end
         hsync_out <= ~(is_lock && (fw < HS_END));
         locked    <= is_lock;
         if (!is_lock)
            vsync_out <= 1'b1;
         else if (ce)
            vsync_out <= vsync_in;
      end
   end

endmodule
